// File: rtl/player_mover_param.sv
// Player sprite controller: STEP-pixel moves from one-hot buttons, wrap/clamp
// screen bounds, and a life counter with a death/respawn/game-over FSM.
module player_mover_param #(
    parameter int COORD_W   = 12,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int STEP      = 12,
    parameter int WRAP_MODE = 1,
    parameter int LIVES     = 3,
    parameter int HOLD_CYC  = 4
) (
    input  logic               btnClk,
    input  logic               rst,
    input  logic               playerDisable,
    input  logic [3:0]         btns,
    input  logic               upEnable,
    input  logic               downEnable,
    input  logic               leftEnable,
    input  logic               rightEnable,
    input  logic [COORD_W-1:0] hStartPos,
    input  logic [COORD_W-1:0] vStartPos,
    input  logic [COORD_W-1:0] objWidth,
    input  logic [COORD_W-1:0] objHeight,
    output logic [COORD_W-1:0] hPos,
    output logic [COORD_W-1:0] vPos,
    output logic               player_dead,
    output logic [3:0]         lives_left,
    output logic               game_over,
    output logic               alive
);

    localparam int XW     = COORD_W + 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [XW-1:0]     SCR_W     = XW'(SCREEN_W);
    localparam logic [XW-1:0]     SCR_H     = XW'(SCREEN_H);
    localparam logic [XW-1:0]     STEP_X    = XW'(STEP);
    localparam logic [3:0]        LIVES_INIT = 4'(LIVES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam bit                WRAP      = (WRAP_MODE != 0);

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_DEAD    = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  hpos_q, hpos_d;
    logic [COORD_W-1:0]  vpos_q, vpos_d;
    logic [3:0]          lives_q, lives_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                dead_q, dead_d;
    logic                over_q;
    logic                alive_q;

    logic [XW-1:0] h_x, v_x, w_x, ht_x;
    logic [XW-1:0] up_x, down_x, left_x, right_x;
    logic          trapped;

    assign h_x  = {1'b0, hpos_q};
    assign v_x  = {1'b0, vpos_q};
    assign w_x  = {1'b0, objWidth};
    assign ht_x = {1'b0, objHeight};

    assign trapped = ~(upEnable | downEnable | leftEnable | rightEnable);

    // Candidate positions are formed in COORD_W+1 bits so nothing goes negative.
    always_comb begin
        up_x    = (v_x >= STEP_X) ? (v_x - STEP_X)
                                  : (WRAP ? (SCR_H - ht_x) : '0);
        down_x  = ((v_x + ht_x + STEP_X) <= SCR_H) ? (v_x + STEP_X)
                                                   : (WRAP ? '0 : (SCR_H - ht_x));
        left_x  = (h_x >= STEP_X) ? (h_x - STEP_X)
                                  : (WRAP ? (SCR_W - w_x) : '0);
        right_x = ((h_x + w_x + STEP_X) <= SCR_W) ? (h_x + STEP_X)
                                                  : (WRAP ? '0 : (SCR_W - w_x));
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        dead_d  = 1'b0;
        unique case (state_q)
            ST_ALIVE: begin
                if (trapped) begin
                    dead_d  = 1'b1;
                    lives_d = lives_q - 4'd1;
                    hold_d  = '0;
                    state_d = (lives_q == 4'd1) ? ST_OVER : ST_DEAD;
                end else if (!playerDisable) begin
                    unique case (btns)
                        4'b1000: if (upEnable)    vpos_d = up_x[COORD_W-1:0];
                        4'b0100: if (downEnable)  vpos_d = down_x[COORD_W-1:0];
                        4'b0010: if (rightEnable) hpos_d = right_x[COORD_W-1:0];
                        4'b0001: if (leftEnable)  hpos_d = left_x[COORD_W-1:0];
                        default: ;
                    endcase
                end
            end
            ST_DEAD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_RESPAWN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RESPAWN: begin
                hpos_d  = hStartPos;
                vpos_d  = vStartPos;
                state_d = ST_ALIVE;
            end
            ST_OVER: ;
            default: state_d = ST_ALIVE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge btnClk) begin
        if (rst) begin
            state_q <= ST_ALIVE;
            hpos_q  <= hStartPos;
            vpos_q  <= vStartPos;
            lives_q <= LIVES_INIT;
            hold_q  <= '0;
            dead_q  <= 1'b0;
            over_q  <= 1'b0;
            alive_q <= 1'b1;
        end else begin
            state_q <= state_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            lives_q <= lives_d;
            hold_q  <= hold_d;
            dead_q  <= dead_d;
            over_q  <= (state_d == ST_OVER);
            alive_q <= (state_d == ST_ALIVE);
        end
    end

    assign hPos        = hpos_q;
    assign vPos        = vpos_q;
    assign player_dead = dead_q;
    assign lives_left  = lives_q;
    assign game_over   = over_q;
    assign alive       = alive_q;

endmodule

// File: doc/player_mover_param.md
Name: player_mover_param

Overview:
Parametrised player-object controller for the VGA game layer. It moves a rectangular sprite in STEP-pixel increments from one-hot button codes, honouring per-direction blocking enables, and keeps the sprite inside a configurable screen in either wrap or clamp mode. It adds a life counter with a death/respawn state machine and a sticky game-over condition. It sits between the debounced button/collision logic and the pixel renderer, and drives absolute sprite coordinates.

Parameters:
COORD_W, 12, width of all coordinate and size buses
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
STEP, 12, pixels moved per accepted button cycle
WRAP_MODE, 1, 1 = wrap to opposite edge, 0 = clamp at edge
LIVES, 3, lives at reset (1..15)
HOLD_CYC, 4, cycles spent in DEAD before respawn (>=1)

Ports:
btnClk  in  1  movement clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
playerDisable  in  1  1 = ignore buttons; the FSM still runs
btns  in  4  button code: 8=U, 4=D, 2=R, 1=L; any other value = no move
upEnable/downEnable/leftEnable/rightEnable  in  1 each  1 = direction free, 0 = blocked by collision logic
hStartPos/vStartPos  in  COORD_W  spawn position (top-left corner)
objWidth/objHeight  in  COORD_W  sprite size
hPos/vPos  out  COORD_W  current top-left corner, registered
player_dead  out  1  one-cycle pulse on each death
lives_left  out  4  remaining lives
game_over  out  1  sticky until rst
alive  out  1  1 while in ALIVE

Behaviour:
- Reset (rst=1 at an edge): state=ALIVE, hPos=hStartPos, vPos=vStartPos, lives_left=LIVES, player_dead=0, game_over=0, alive=1, hold counter=0.
- States: ALIVE, DEAD, RESPAWN, OVER.
- Trapped = all four enables 0.
- ALIVE transitions:
  - If trapped, go to DEAD. player_dead=1 for that cycle only. lives_left decrements. No move happens in that cycle.
  - If lives_left was 1, go to OVER instead of DEAD. player_dead still pulses and lives_left becomes 0.
- DEAD: position frozen, buttons ignored. The hold counter counts HOLD_CYC cycles, then the block moves to RESPAWN.
- RESPAWN: one cycle. Loads hPos=hStartPos and vPos=vStartPos, then returns to ALIVE. Trapped is not evaluated in RESPAWN.
- OVER: position frozen, game_over=1, alive=0. Leaves OVER only on rst.
- Movement happens in ALIVE only, when playerDisable=0, btns is exactly one of 8/4/2/1, the matching enable is 1, and the cycle is not trapped. The position updates on the same edge (1-cycle latency to hPos/vPos).
- Arithmetic uses COORD_W+1 bits, unsigned, with no negative intermediates.
  - Up: if vPos>=STEP then vPos-STEP; else wrap -> SCREEN_H-objHeight, clamp -> 0.
  - Down: if vPos+objHeight+STEP<=SCREEN_H then vPos+STEP; else wrap -> 0, clamp -> SCREEN_H-objHeight.
  - Left/Right: same rules using hPos, objWidth and SCREEN_W.
- An exact landing on an edge counts as in range (no wrap).
- Multi-button or zero codes produce no move.
- The block does not check that objWidth/objHeight fit the screen; callers guarantee it.
- rst while in DEAD or OVER restores the full reset state on that edge.
- Start-position inputs are sampled only at reset and in RESPAWN.

Test Plan:
1. Reset with hStart=100, vStart=200 -> hPos=100, vPos=200, lives_left=3, alive=1. Then btns=2, rightEnable=1 -> hPos=112 on the next edge.
2. WRAP_MODE=1, vPos=6, objHeight=20, btns=8 -> vPos=460. Then btns=4 at vPos=460 -> vPos=0. With WRAP_MODE=0, the same up press -> vPos=0 and the down press at 460 -> 460.
3. btns=8 with upEnable=0 -> no move. btns=6 -> no move. playerDisable=1 with btns=2 -> no move.
4. All enables 0 for one cycle at hPos=300 -> player_dead high exactly one cycle, lives_left=2, 4 frozen cycles, then hPos/vPos = start values and alive=1.
5. Three traps with LIVES=3 -> third pulse gives lives_left=0 and game_over=1. Later button presses and traps cause no change until rst, which restores lives_left=3.
6. Assert rst during the second DEAD hold cycle -> next edge shows ALIVE, lives_left=3, position at start, and no player_dead pulse.
